// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, ALU operations,
// opcode/funct values and datapath mux select codes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF    = 3'd0,
        S_ID    = 3'd1,
        S_EXE   = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_FAULT = 3'd5
    } state_e;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_RS    = 2'd1;
    localparam logic [1:0] SRCA_SHAMT = 2'd2;

    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;
    localparam logic [1:0] SRCB_BOFS = 2'd3;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_RS     = 2'd3;

    localparam logic [1:0] GPR_RD  = 2'd0;
    localparam logic [1:0] GPR_RT  = 2'd1;
    localparam logic [1:0] GPR_R31 = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC  = 2'd2;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct decode into instruction-class flags plus the ALU
// operation the instruction needs in EXE.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic       rtype_alu,
    output logic       shift,
    output logic       itype_alu,
    output logic       zext,
    output logic       load,
    output logic       store,
    output logic       beq,
    output logic       bne,
    output logic       j,
    output logic       jal,
    output logic       jr,
    output logic       jalr,
    output logic       illegal,
    output logic [3:0] alu_op
);

    always_comb begin
        rtype_alu = 1'b0;
        shift     = 1'b0;
        itype_alu = 1'b0;
        zext      = 1'b0;
        load      = 1'b0;
        store     = 1'b0;
        beq       = 1'b0;
        bne       = 1'b0;
        j         = 1'b0;
        jal       = 1'b0;
        jr        = 1'b0;
        jalr      = 1'b0;
        illegal   = 1'b0;
        alu_op    = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU: rtype_alu = 1'b1;
                    F_SUB, F_SUBU: begin rtype_alu = 1'b1; alu_op = ALU_SUB;  end
                    F_AND:         begin rtype_alu = 1'b1; alu_op = ALU_AND;  end
                    F_OR:          begin rtype_alu = 1'b1; alu_op = ALU_OR;   end
                    F_SLT:         begin rtype_alu = 1'b1; alu_op = ALU_SLT;  end
                    F_SLTU:        begin rtype_alu = 1'b1; alu_op = ALU_SLTU; end
                    F_SLL:         begin shift = 1'b1;     alu_op = ALU_SLL;  end
                    F_SRL:         begin shift = 1'b1;     alu_op = ALU_SRL;  end
                    F_SRA:         begin shift = 1'b1;     alu_op = ALU_SRA;  end
                    F_JR:          jr   = 1'b1;
                    F_JALR:        jalr = 1'b1;
                    default:       illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU: itype_alu = 1'b1;
            OP_SLTI: begin itype_alu = 1'b1; alu_op = ALU_SLT; end
            OP_ANDI: begin itype_alu = 1'b1; zext = 1'b1; alu_op = ALU_AND; end
            OP_ORI:  begin itype_alu = 1'b1; zext = 1'b1; alu_op = ALU_OR;  end
            OP_LUI:  begin itype_alu = 1'b1; zext = 1'b1; alu_op = ALU_LUI; end
            OP_LW:   load  = 1'b1;
            OP_SW:   store = 1'b1;
            OP_BEQ:  begin beq = 1'b1; alu_op = ALU_SUB; end
            OP_BNE:  begin bne = 1'b1; alu_op = ALU_SUB; end
            OP_J:    j   = 1'b1;
            OP_JAL:  jal = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multicycle MIPS control FSM with req/ack memory handshaking on fetch and data
// phases, a stall watchdog and sticky fault flags.
module mc_ctrl_hs
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       zero,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       i_or_d,
    output logic       mem_write,
    output logic       reg_write,
    output logic       pc_write,
    output logic       ir_write,
    output logic       ext_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic [1:0] pc_source,
    output logic [1:0] gpr_sel,
    output logic [1:0] wd_sel,
    output logic       fault_illegal,
    output logic       fault_timeout,
    output logic [2:0] state
);

    // A zero TIMEOUT still needs a one-bit counter to keep the declarations legal.
    localparam int CNT_WE = (CNT_W < 1) ? 1 : CNT_W;
    localparam logic [CNT_WE-1:0] CNT_LIMIT = CNT_WE'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e            state_q, state_d;
    logic [CNT_WE-1:0] wait_cnt_q, wait_cnt_d;
    logic              fault_illegal_q, fault_illegal_d;
    logic              fault_timeout_q, fault_timeout_d;

    logic       dec_rtype_alu, dec_shift, dec_itype_alu, dec_zext;
    logic       dec_load, dec_store, dec_beq, dec_bne;
    logic       dec_j, dec_jal, dec_jr, dec_jalr, dec_illegal;
    logic [3:0] dec_alu_op;
    logic       req_wait, wd_expire;

    mc_decode u_decode (
        .op        (op),
        .funct     (funct),
        .rtype_alu (dec_rtype_alu),
        .shift     (dec_shift),
        .itype_alu (dec_itype_alu),
        .zext      (dec_zext),
        .load      (dec_load),
        .store     (dec_store),
        .beq       (dec_beq),
        .bne       (dec_bne),
        .j         (dec_j),
        .jal       (dec_jal),
        .jr        (dec_jr),
        .jalr      (dec_jalr),
        .illegal   (dec_illegal),
        .alu_op    (dec_alu_op)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IF;
            wait_cnt_q      <= '0;
            fault_illegal_q <= 1'b0;
            fault_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            wait_cnt_q      <= wait_cnt_d;
            fault_illegal_q <= fault_illegal_d;
            fault_timeout_q <= fault_timeout_d;
        end
    end

    assign req_wait  = ((state_q == S_IF) || (state_q == S_MEM)) && !mem_ack;
    assign wd_expire = (TIMEOUT != 0) && req_wait && (wait_cnt_q == CNT_LIMIT);

    always_comb begin
        state_d         = state_q;
        fault_illegal_d = fault_illegal_q;
        fault_timeout_d = fault_timeout_q;
        mem_req         = 1'b0;
        i_or_d          = 1'b0;
        mem_write       = 1'b0;
        reg_write       = 1'b0;
        pc_write        = 1'b0;
        ir_write        = 1'b0;
        ext_op          = 1'b1;
        alu_src_a       = SRCA_RS;
        alu_src_b       = SRCB_RT;
        alu_op          = ALU_ADD;
        pc_source       = PCS_ALU;
        gpr_sel         = GPR_RD;
        wd_sel          = WD_ALU;

        case (state_q)
            S_IF: begin
                mem_req   = 1'b1;
                alu_src_a = SRCA_PC;
                alu_src_b = SRCB_FOUR;
                if (mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_ID;
                end
            end
            S_ID: begin
                if (dec_j || dec_jal) begin
                    pc_source = PCS_JUMP;
                    pc_write  = 1'b1;
                    state_d   = S_IF;
                    if (dec_jal) begin
                        reg_write = 1'b1;
                        gpr_sel   = GPR_R31;
                        wd_sel    = WD_PC;
                    end
                end else if (dec_jr || dec_jalr) begin
                    pc_source = PCS_RS;
                    pc_write  = 1'b1;
                    state_d   = S_IF;
                    if (dec_jalr) begin
                        reg_write = 1'b1;
                        wd_sel    = WD_PC;
                    end
                end else if (dec_illegal) begin
                    state_d         = S_FAULT;
                    fault_illegal_d = 1'b1;
                end else begin
                    // Precompute the branch target while the register file is read.
                    alu_src_a = SRCA_PC;
                    alu_src_b = SRCB_BOFS;
                    state_d   = S_EXE;
                end
            end
            S_EXE: begin
                alu_op = dec_alu_op;
                if (dec_beq || dec_bne) begin
                    pc_source = PCS_ALUOUT;
                    pc_write  = dec_beq ? zero : ~zero;
                    state_d   = S_IF;
                end else if (dec_load || dec_store) begin
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_ADD;
                    state_d   = S_MEM;
                end else begin
                    if (dec_shift) alu_src_a = SRCA_SHAMT;
                    if (dec_itype_alu) begin
                        alu_src_b = SRCB_IMM;
                        ext_op    = ~dec_zext;
                    end
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req   = 1'b1;
                i_or_d    = 1'b1;
                mem_write = dec_store;
                if (mem_ack) state_d = dec_load ? S_WB : S_IF;
            end
            S_WB: begin
                reg_write = 1'b1;
                if (dec_load) wd_sel = WD_MEM;
                if (!(dec_rtype_alu || dec_shift)) gpr_sel = GPR_RT;
                state_d = S_IF;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IF;
        endcase

        // An ack in the limit cycle wins because wd_expire requires mem_ack low.
        if (wd_expire) begin
            state_d         = S_FAULT;
            fault_timeout_d = 1'b1;
        end

        if (rst) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            pc_write  = 1'b0;
            ir_write  = 1'b0;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if ((state_d != state_q) && ((state_d == S_IF) || (state_d == S_MEM)))
            wait_cnt_d = '0;
        else if (req_wait)
            wait_cnt_d = wait_cnt_q + CNT_WE'(1);
    end

    assign fault_illegal = fault_illegal_q;
    assign fault_timeout = fault_timeout_q;
    assign state         = state_q;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Bench for mc_ctrl_hs: a per-cycle vector table run through a scoreboard queue,
// then hand-written reset, watchdog and illegal-opcode sequences.
module tb_mc_ctrl_hs;

    logic       clk = 1'b0;
    logic       rst;
    logic       zero;
    logic [5:0] op;
    logic [5:0] funct;
    logic       mem_ack;
    logic       mem_req, i_or_d, mem_write, reg_write, pc_write, ir_write, ext_op;
    logic [1:0] alu_src_a, alu_src_b, pc_source, gpr_sel, wd_sel;
    logic [3:0] alu_op;
    logic       fault_illegal, fault_timeout;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    mc_ctrl_hs #(.TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .zero          (zero),
        .op            (op),
        .funct         (funct),
        .mem_ack       (mem_ack),
        .mem_req       (mem_req),
        .i_or_d        (i_or_d),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .ext_op        (ext_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .gpr_sel       (gpr_sel),
        .wd_sel        (wd_sel),
        .fault_illegal (fault_illegal),
        .fault_timeout (fault_timeout),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Enable bits, in the order {mem_req, mem_write, reg_write, pc_write, ir_write}.
    localparam logic [4:0] REQ = 5'b10000;
    localparam logic [4:0] MW  = 5'b01000;
    localparam logic [4:0] RW  = 5'b00100;
    localparam logic [4:0] PW  = 5'b00010;
    localparam logic [4:0] IRW = 5'b00001;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        ack;
        logic [25:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [25:0] sb_q[$];
    logic [25:0] act;

    assign act = {state, mem_req, mem_write, reg_write, pc_write, ir_write, i_or_d, ext_op,
                  alu_src_a, alu_src_b, alu_op, pc_source, gpr_sel, wd_sel,
                  fault_illegal, fault_timeout};

    function automatic logic [25:0] e(input logic [2:0] st, input logic [4:0] en,
                                      input logic iod, input logic ext,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [3:0] aop, input logic [1:0] pcs,
                                      input logic [1:0] gs, input logic [1:0] ws);
        return {st, en, iod, ext, sa, sb, aop, pcs, gs, ws, 2'b00};
    endfunction

    task automatic add(input string name, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic a, input logic [25:0] x);
        vec_t v;
        v.name = name; v.op = o; v.funct = f; v.zero = z; v.ack = a; v.exp = x;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1; mem_ack = 1'b0; op = 6'h00; funct = 6'h20; zero = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    logic [25:0] IFA, IFN, IDX;

    initial begin
        IFA = e(3'd0, REQ | PW | IRW, 1'b0, 1'b1, 2'd0, 2'd1, 4'd1, 2'd0, 2'd0, 2'd0);
        IFN = e(3'd0, REQ,            1'b0, 1'b1, 2'd0, 2'd1, 4'd1, 2'd0, 2'd0, 2'd0);
        IDX = e(3'd1, 5'b0,           1'b0, 1'b1, 2'd0, 2'd3, 4'd1, 2'd0, 2'd0, 2'd0);

        add("add_if",   6'h00, 6'h20, 0, 1, IFA);
        add("add_id",   6'h00, 6'h20, 0, 1, IDX);
        add("add_exe",  6'h00, 6'h20, 0, 1, e(2, 0,   0, 1, 1, 0, 1, 0, 0, 0));
        add("add_wb",   6'h00, 6'h20, 0, 1, e(4, RW,  0, 1, 1, 0, 1, 0, 0, 0));
        add("lw_if",    6'h23, 6'h00, 0, 1, IFA);
        add("lw_id",    6'h23, 6'h00, 0, 1, IDX);
        add("lw_exe",   6'h23, 6'h00, 0, 1, e(2, 0,   0, 1, 1, 2, 1, 0, 0, 0));
        add("lw_mem1",  6'h23, 6'h00, 0, 0, e(3, REQ, 1, 1, 1, 0, 1, 0, 0, 0));
        add("lw_mem2",  6'h23, 6'h00, 0, 0, e(3, REQ, 1, 1, 1, 0, 1, 0, 0, 0));
        add("lw_mem3",  6'h23, 6'h00, 0, 0, e(3, REQ, 1, 1, 1, 0, 1, 0, 0, 0));
        add("lw_mem4",  6'h23, 6'h00, 0, 1, e(3, REQ, 1, 1, 1, 0, 1, 0, 0, 0));
        add("lw_wb",    6'h23, 6'h00, 0, 1, e(4, RW,  0, 1, 1, 0, 1, 0, 1, 1));
        add("bne0_if",  6'h05, 6'h00, 0, 1, IFA);
        add("bne0_id",  6'h05, 6'h00, 0, 1, IDX);
        add("bne0_exe", 6'h05, 6'h00, 0, 1, e(2, PW,  0, 1, 1, 0, 2, 1, 0, 0));
        add("bne1_if",  6'h05, 6'h00, 1, 1, IFA);
        add("bne1_id",  6'h05, 6'h00, 1, 1, IDX);
        add("bne1_exe", 6'h05, 6'h00, 1, 1, e(2, 0,   0, 1, 1, 0, 2, 1, 0, 0));
        add("jalr_if",  6'h00, 6'h09, 0, 1, IFA);
        add("jalr_id",  6'h00, 6'h09, 0, 1, e(1, RW | PW, 0, 1, 1, 0, 1, 3, 0, 2));
        add("sw_ifw",   6'h2B, 6'h00, 0, 0, IFN);
        add("sw_if",    6'h2B, 6'h00, 0, 1, IFA);
        add("sw_id",    6'h2B, 6'h00, 0, 1, IDX);
        add("sw_exe",   6'h2B, 6'h00, 0, 1, e(2, 0,   0, 1, 1, 2, 1, 0, 0, 0));
        add("sw_mem",   6'h2B, 6'h00, 0, 1, e(3, REQ | MW, 1, 1, 1, 0, 1, 0, 0, 0));
        add("ori_if",   6'h0D, 6'h00, 0, 1, IFA);
        add("ori_id",   6'h0D, 6'h00, 0, 1, IDX);
        add("ori_exe",  6'h0D, 6'h00, 0, 1, e(2, 0,   0, 0, 1, 2, 4, 0, 0, 0));
        add("ori_wb",   6'h0D, 6'h00, 0, 1, e(4, RW,  0, 1, 1, 0, 1, 0, 1, 0));
        add("sll_if",   6'h00, 6'h00, 0, 1, IFA);
        add("sll_id",   6'h00, 6'h00, 0, 1, IDX);
        add("sll_exe",  6'h00, 6'h00, 0, 1, e(2, 0,   0, 1, 2, 0, 7, 0, 0, 0));
        add("sll_wb",   6'h00, 6'h00, 0, 1, e(4, RW,  0, 1, 1, 0, 1, 0, 0, 0));
        add("jal_if",   6'h03, 6'h00, 0, 1, IFA);
        add("jal_id",   6'h03, 6'h00, 0, 1, e(1, RW | PW, 0, 1, 1, 0, 1, 2, 2, 2));
        add("lui_if",   6'h0F, 6'h00, 0, 1, IFA);
        add("lui_id",   6'h0F, 6'h00, 0, 1, IDX);
        add("lui_exe",  6'h0F, 6'h00, 0, 1, e(2, 0,   0, 0, 1, 2, 10, 0, 0, 0));
        add("lui_wb",   6'h0F, 6'h00, 0, 1, e(4, RW,  0, 1, 1, 0, 1, 0, 1, 0));
        add("beq_if",   6'h04, 6'h00, 1, 1, IFA);
        add("beq_id",   6'h04, 6'h00, 1, 1, IDX);
        add("beq_exe",  6'h04, 6'h00, 1, 1, e(2, PW,  0, 1, 1, 0, 2, 1, 0, 0));
        add("j_if",     6'h02, 6'h00, 0, 1, IFA);
        add("j_id",     6'h02, 6'h00, 0, 1, e(1, PW,  0, 1, 1, 0, 1, 2, 0, 0));
        add("slti_if",  6'h0A, 6'h00, 0, 1, IFA);
        add("slti_id",  6'h0A, 6'h00, 0, 1, IDX);
        add("slti_exe", 6'h0A, 6'h00, 0, 1, e(2, 0,   0, 1, 1, 2, 5, 0, 0, 0));
        add("slti_wb",  6'h0A, 6'h00, 0, 1, e(4, RW,  0, 1, 1, 0, 1, 0, 1, 0));
        add("next_if",  6'h00, 6'h20, 0, 0, IFN);

        // Reset state, with ack high so that forcing of the enables is visible.
        rst = 1'b1; mem_ack = 1'b1; op = 6'h00; funct = 6'h20; zero = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst_vec", {6'b0, act}, {6'b0, e(0, 5'b0, 0, 1, 0, 1, 1, 0, 0, 0)});
        @(posedge clk); #1;
        rst = 1'b0;

        // Vector table through the scoreboard.
        foreach (vecs[i]) begin
            op = vecs[i].op; funct = vecs[i].funct; zero = vecs[i].zero; mem_ack = vecs[i].ack;
            sb_q.push_back(vecs[i].exp);
            @(negedge clk);
            if (sb_q.size() == 0) begin
                chk({"sb_empty_", vecs[i].name}, 32'd0, 32'd1);
            end else begin
                chk(vecs[i].name, {6'b0, act}, {6'b0, sb_q.pop_front()});
            end
            @(posedge clk); #1;
        end

        // Watchdog: no ack for TIMEOUT fetch cycles.
        reset_dut();
        cycles(3);
        chk("to_pre_state", {29'b0, state}, 32'd0);
        cycles(1);
        chk("to_state", {29'b0, state}, 32'd5);
        chk("to_flag", {31'b0, fault_timeout}, 32'd1);
        chk("to_illegal_clear", {31'b0, fault_illegal}, 32'd0);
        mem_ack = 1'b1;
        cycles(3);
        chk("to_hold_state", {29'b0, state}, 32'd5);
        chk("to_hold_en", {27'b0, mem_req, mem_write, reg_write, pc_write, ir_write}, 32'd0);
        chk("to_hold_vec", {6'b0, act}, {6'b0, e(5, 0, 0, 1, 1, 0, 1, 0, 0, 0)} | 32'd1);

        // Ack arriving on the last allowed cycle is accepted.
        reset_dut();
        cycles(3);
        mem_ack = 1'b1;
        @(negedge clk);
        chk("to_edge_irw", {31'b0, ir_write}, 32'd1);
        @(posedge clk); #1;
        chk("to_edge_state", {29'b0, state}, 32'd1);
        chk("to_edge_flag", {31'b0, fault_timeout}, 32'd0);

        // Illegal opcode is caught in ID.
        reset_dut();
        op = 6'h3F; mem_ack = 1'b1;
        cycles(2);
        chk("ill_state", {29'b0, state}, 32'd5);
        chk("ill_flag", {31'b0, fault_illegal}, 32'd1);
        chk("ill_to_clear", {31'b0, fault_timeout}, 32'd0);
        cycles(2);
        chk("ill_hold_en", {27'b0, mem_req, mem_write, reg_write, pc_write, ir_write}, 32'd0);

        // Reset pulse in the middle of a stalled sw data phase.
        reset_dut();
        op = 6'h2B; funct = 6'h00; mem_ack = 1'b1;
        cycles(2);
        mem_ack = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("sw_mem_state", {29'b0, state}, 32'd3);
        chk("sw_mem_write", {31'b0, mem_write}, 32'd1);
        rst = 1'b1;
        #1;
        chk("sw_rst_state", {29'b0, state}, 32'd0);
        chk("sw_rst_en", {27'b0, mem_req, mem_write, reg_write, pc_write, ir_write}, 32'd0);
        @(posedge clk); #1;
        chk("sw_rst_hold_mw", {31'b0, mem_write}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("sw_rel_req", {31'b0, mem_req}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_hs.md
# mc_ctrl_hs

Parametrised multicycle MIPS control unit, next generation of the single-ISA FSM controller. It adds wait-state memory handshaking (req/ack) on both the fetch and data phases, a programmable stall watchdog, and a sticky fault state. The ISA is extended with bne, addiu/slti/andi/lui, the shifts sll/srl/sra, and jr/jalr. It sits between the IR/opcode decode and the multicycle datapath muxes and enables.

## Interface
Parameters:
- TIMEOUT, default 15: maximum consecutive request cycles without mem_ack; 0 disables the watchdog.
- CNT_W, default $clog2(TIMEOUT+1): watchdog counter width (derived).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- zero  in  1  ALU zero flag.
- op  in  6  opcode.
- funct  in  6  R-type function field.
- mem_ack  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- i_or_d  out  1  0 instruction address (PC), 1 data address (ALUOut).
- mem_write  out  1  store strobe; valid only with mem_req.
- reg_write, pc_write, ir_write  out  1 each  register-file, PC and IR write enables.
- ext_op  out  1  1 sign-extend, 0 zero-extend.
- alu_src_a  out  2  0 PC, 1 rs, 2 shamt.
- alu_src_b  out  2  0 rt, 1 const 4, 2 ext imm, 3 branch offset.
- alu_op  out  4  NOP0 ADD1 SUB2 AND3 OR4 SLT5 SLTU6 SLL7 SRL8 SRA9 LUI10.
- pc_source  out  2  0 ALU, 1 ALUOut, 2 jump target, 3 rs.
- gpr_sel  out  2  0 rd, 1 rt, 2 r31.
- wd_sel  out  2  0 ALU, 1 MEM, 2 PC.
- fault_illegal, fault_timeout  out  1 each  sticky fault flags.
- state  out  3  current state, for debug.

## Operation
- States: IF 0, ID 1, EXE 2, MEM 3, WB 4, FAULT 5. Other encodings go to IF.
- Outputs are combinational from state, decoded instruction, zero and mem_ack.
- Defaults: all enables 0, ext_op 1, alu_src_a 1, alu_src_b 0, alu_op ADD, other selects 0.
- IF:
  - Drives mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=1.
  - ir_write and pc_write are asserted only in the cycle mem_ack=1; that cycle moves to ID. Otherwise the block stays in IF.
- ID:
  - j: pc_source=2, pc_write, go to IF.
  - jal: same as j, plus reg_write, gpr_sel=2, wd_sel=2.
  - jr: pc_source=3, pc_write, go to IF.
  - jalr: same as jr, plus reg_write, gpr_sel=0, wd_sel=2.
  - Unrecognised op/funct: go to FAULT and set fault_illegal.
  - All other instructions: alu_src_a=0, alu_src_b=3, go to EXE.
- EXE:
  - beq: alu_op=SUB, pc_source=1, pc_write=zero, go to IF.
  - bne: same as beq but pc_write=~zero.
  - lw/sw: alu_src_b=2, ADD, go to MEM.
  - Shifts: alu_src_a=2, alu_src_b=0.
  - I-type ALU instructions: alu_src_b=2. andi, ori and lui use ext_op=0.
  - Everything else goes to WB.
- MEM:
  - Drives mem_req=1, i_or_d=1, mem_write=sw.
  - Waits for mem_ack. On ack, lw goes to WB and sw goes to IF.
- WB:
  - reg_write=1, go to IF.
  - lw uses wd_sel=1.
  - I-type instructions use gpr_sel=1.
- FAULT: every output at its default and all enables 0. The state is only left by reset.
- Decoded opcodes (hex):
  - I/J-type: addi 08, addiu 09, slti 0A, andi 0C, ori 0D, lui 0F, lw 23, sw 2B, beq 04, bne 05, j 02, jal 03.
  - R-type funct: add 20, addu 21, sub 22, subu 23, and 24, or 25, slt 2A, sltu 2B, sll 00, srl 02, sra 03, jr 08, jalr 09.

## Timing
- Reset: state=IF, wait_cnt=0, fault flags=0.
- While rst is high, mem_req, pc_write, ir_write, reg_write and mem_write are forced to 0. All other outputs take their IF values.
- Cycle counts with zero-wait memory:
  - Jumps: 2 cycles.
  - Branches: 3 cycles.
  - ALU instructions: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
- Each IF or MEM wait cycle adds 1.
- Watchdog:
  - wait_cnt clears on entering IF or MEM and increments on each non-ack request cycle.
  - If wait_cnt==TIMEOUT-1 and mem_ack=0, the next state is FAULT and fault_timeout is set.
  - An ack arriving in that same cycle is accepted normally.
- mem_ack outside IF/MEM is ignored.
- Reset asserted mid-instruction aborts the instruction immediately. No write enable may be seen after rst rises.

## Structure
- Package mc_ctrl_pkg holds:
  - state encodings;
  - ALU op codes;
  - opcode and funct constants;
  - encodings for alu_src_a/b, pc_source, gpr_sel and wd_sel.
- One sub-module, mc_decode: combinational op/funct decode producing instruction-class flags (rtype_alu, shift, itype_alu, zext, load, store, beq, bne, j, jal, jr, jalr, illegal).
- The top level holds the FSM, watchdog counter, fault flags and output decode.

## Test plan
- add (op 00, funct 20), mem_ack tied 1 → states IF,ID,EXE,WB. reg_write=1 in WB only, with gpr_sel=0 and wd_sel=0.
- lw (op 23), ack delayed 3 cycles in MEM → 3 extra MEM cycles with mem_req=1 and i_or_d=1. WB has wd_sel=1 and gpr_sel=1.
- bne (op 05): zero=0 → pc_write=1 and pc_source=1 in EXE; zero=1 → pc_write=0. Both return to IF.
- jalr (funct 09) → 2-cycle instruction. ID shows pc_source=3, reg_write=1 and wd_sel=2.
- TIMEOUT=4, no ack in IF → FAULT after the 4th request cycle, fault_timeout=1, enables held 0 until rst. Repeat with ack in the 4th cycle → goes to ID, no fault.
- op 3F → FAULT from ID with fault_illegal=1. rst pulse mid-MEM of sw → state IF, mem_write=0 during reset.
